// File: rtl/pc_pkg.sv
// Shared CPU package: Hack word type and the program-counter defaults.
package pc_pkg;
  localparam int PC_WIDTH = 16;

  typedef logic [15:0] word_t;

  localparam word_t PC_RESET_VALUE = 16'h0000;
endpackage

// File: rtl/inc16.sv
// Combinational +1 adder, wraps modulo 2^WIDTH; shared with the ALU.
module inc16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = a + WIDTH'(1);
endmodule

// File: rtl/pc.sv
// Program counter: load beats increment beats hold, async active-low reset.
module pc
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_nxt;

  inc16 #(.WIDTH(WIDTH)) u_inc (
    .a (cnt),
    .y (cnt_inc)
  );

  always_comb begin
    cnt_nxt = cnt;
    if (load)     cnt_nxt = in;
    else if (inc) cnt_nxt = cnt_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= RESET_VALUE;
    else          cnt <= cnt_nxt;
  end

  // out is the register itself: no input-to-output combinational path.
  assign out = cnt;
endmodule

// File: tb/tb_pc.sv
// Directed + random scoreboard bench for the program counter.
module tb_pc;
  localparam int W = 16;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in;
  logic         load;
  logic         inc;
  logic [W-1:0] out;

  logic [W-1:0] q[$];
  logic [W-1:0] model;
  int vectors;
  int miscompares;

  pc #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .inc     (inc),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [W-1:0] exp;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, out=%h", tag, out);
    end else begin
      exp = q.pop_front();
      vectors++;
      assert (out === exp) else begin
        miscompares++;
        $error("FAIL %s: out=%h expected=%h", tag, out, exp);
      end
    end
  endtask

  // Drive one cycle, predict the result, compare #1 after the edge.
  task automatic cycle(input logic l, input logic i, input logic [W-1:0] d,
                       input string tag);
    load = l;
    inc  = i;
    in   = d;
    if (!reset_n)  model = 16'h0000;
    else if (l)    model = d;
    else if (i)    model = model + 16'h0001;
    q.push_back(model);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model   = 16'h0000;
    reset_n = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    in      = 16'h0000;

    #1;
    q.push_back(16'h0000);
    check("reset_pre_edge");
    cycle(1'b0, 1'b0, 16'h0000, "reset_post_edge");

    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 16'h1234, "load_1234");
    cycle(1'b0, 1'b1, 16'h0000, "inc_1235");
    cycle(1'b0, 1'b0, 16'hBEEF, "hold_ignores_in");
    cycle(1'b1, 1'b1, 16'h00FF, "load_beats_inc");
    cycle(1'b1, 1'b0, 16'hFFFF, "load_ffff");
    cycle(1'b0, 1'b1, 16'h0000, "wrap_0000");

    cycle(1'b1, 1'b0, 16'h0010, "load_0010");
    cycle(1'b0, 1'b1, 16'h0000, "inc_0011");
    cycle(1'b0, 1'b1, 16'h0000, "inc_0012");
    cycle(1'b0, 1'b1, 16'h0000, "inc_0013");

    // Drop reset between edges: out must clear without a clock edge.
    #2;
    reset_n = 1'b0;
    model   = 16'h0000;
    #1;
    q.push_back(16'h0000);
    check("async_reset_immediate");
    cycle(1'b1, 1'b1, 16'hAAAA, "reset_blocks_load");

    #2;
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 16'h0000, "release_inc_0001");
    cycle(1'b0, 1'b1, 16'h0000, "inc_0002");

    for (int n = 0; n < 40; n++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            16'($urandom), "random");
    end

    cycle(1'b1, 1'b0, 16'hFFFE, "load_fffe");
    cycle(1'b0, 1'b1, 16'h0000, "inc_ffff");
    cycle(1'b0, 1'b1, 16'h0000, "wrap_again");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
